// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: state encoding, halt encoding, ROM geometry.
package fetch_pkg;

   localparam int PC_W      = 64;
   localparam int INSN_W    = 32;
   localparam int IMEM_AW   = 8;
   localparam int ROM_DEPTH = 1 << IMEM_AW;

   // CBZ XZR,#0: a self-loop the program uses to signal completion.
   localparam logic [INSN_W-1:0] HALT_INSN = 32'hb400001f;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: loads on en_i, flush_i clears only the valid bit.
// Latency one edge; when neither en_i nor flush_i is set the contents hold.
module if_id_reg #(
   parameter int N  = 64,
   parameter int IW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en_i,
   input  logic          flush_i,
   input  logic [IW-1:0] instr_i,
   input  logic [N-1:0]  pc_i,
   output logic [IW-1:0] instr_o,
   output logic [N-1:0]  pc_o,
   output logic          valid_o
);

   logic [IW-1:0] instr_q;
   logic [N-1:0]  pc_q;
   logic          valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (en_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
         valid_q <= 1'b1;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the instruction ROM, fills IF/ID, detects halt/fault.
// Latency: word at pc_F lands in IF/ID one edge later; stall_F holds PC and IF/ID.
module fetch_ctrl #(
   parameter int N  = fetch_pkg::PC_W,
   parameter int IW = fetch_pkg::INSN_W,
   parameter int AW = fetch_pkg::IMEM_AW,
   parameter logic [IW-1:0] HALT_INSN = fetch_pkg::HALT_INSN
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall_F,
   input  logic          redirect_valid,
   input  logic [N-1:0]  redirect_pc,
   output logic [AW-1:0] imem_addr,
   input  logic [IW-1:0] imem_q,
   output logic [IW-1:0] instr_D,
   output logic [N-1:0]  pc_D,
   output logic          valid_D,
   output logic          halted,
   output logic          fault,
   output logic [31:0]   fetch_count
);
   import fetch_pkg::*;

   fetch_state_t state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic         halted_q, halted_d;
   logic         fault_q, fault_d;
   logic [31:0]  cnt_q, cnt_d;
   logic         ifid_en, ifid_flush;
   logic         pc_bad;

   // Address comes straight from the PC register, never from redirect/stall.
   assign imem_addr = pc_q[AW+1:2];
   assign pc_bad    = (pc_q[N-1:AW+2] != '0) || (pc_q[1:0] != 2'b00);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      halted_d   = halted_q;
      fault_d    = fault_q;
      cnt_d      = cnt_q;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      case (state_q)
         RUN: begin
            if (redirect_valid) begin
               pc_d       = redirect_pc;
               ifid_flush = 1'b1;
            end else if (pc_bad) begin
               state_d    = FAULT;
               fault_d    = 1'b1;
               ifid_flush = 1'b1;
            end else if (!stall_F) begin
               ifid_en = 1'b1;
               if (cnt_q != 32'hffffffff) cnt_d = cnt_q + 32'd1;
               if (imem_q == HALT_INSN) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d = pc_q + N'(4);
               end
            end
         end
         // The halt word already in IF/ID drains on the first unstalled edge.
         HALT:    if (!stall_F) ifid_flush = 1'b1;
         FAULT:   ifid_flush = 1'b1;
         default: ifid_flush = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         pc_q     <= '0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
         cnt_q    <= cnt_d;
      end
   end

   if_id_reg #(.N(N), .IW(IW)) u_if_id (
      .clk     (clk),
      .reset   (reset),
      .en_i    (ifid_en),
      .flush_i (ifid_flush),
      .instr_i (imem_q),
      .pc_i    (pc_q),
      .instr_o (instr_D),
      .pc_o    (pc_D),
      .valid_o (valid_D)
   );

   assign halted      = halted_q;
   assign fault       = fault_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural ROM: word k = A000_0000+k, word 20 = halt.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset, stall_F, redirect_valid;
   logic [63:0] redirect_pc;
   logic [7:0]  imem_addr;
   logic [31:0] imem_q, instr_D, fetch_count;
   logic [63:0] pc_D;
   logic        valid_D, halted, fault;

   logic [31:0] rom [256];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign imem_q = rom[imem_addr];

   fetch_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .stall_F        (stall_F),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_q         (imem_q),
      .instr_D        (instr_D),
      .pc_D           (pc_D),
      .valid_D        (valid_D),
      .halted         (halted),
      .fault          (fault),
      .fetch_count    (fetch_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_addr"},   64'(imem_addr),   64'd0);
      chk({tag, "_instr"},  64'(instr_D),     64'd0);
      chk({tag, "_pcD"},    pc_D,             64'd0);
      chk({tag, "_valid"},  64'(valid_D),     64'd0);
      chk({tag, "_halted"}, 64'(halted),      64'd0);
      chk({tag, "_fault"},  64'(fault),       64'd0);
      chk({tag, "_count"},  64'(fetch_count), 64'd0);
   endtask

   initial begin
      for (int k = 0; k < 256; k++) rom[k] = 32'ha0000000 + 32'(k);
      rom[20] = 32'hb400001f;

      reset = 1'b1; stall_F = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      step(); step();
      chk_reset_state("rst");
      reset = 1'b0;

      // Straight-line fetch of words 0..3
      for (int i = 0; i < 4; i++) begin
         step();
         chk("sl_pcD",   pc_D,             64'(4 * i));
         chk("sl_instr", 64'(instr_D),     64'(32'ha0000000 + 32'(i)));
         chk("sl_valid", 64'(valid_D),     64'd1);
         chk("sl_addr",  64'(imem_addr),   64'(i + 1));
      end
      chk("sl_count", 64'(fetch_count), 64'd4);

      // Stall at pc_F=16
      stall_F = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_addr",  64'(imem_addr),   64'd4);
         chk("st_pcD",   pc_D,             64'd12);
         chk("st_count", 64'(fetch_count), 64'd4);
         chk("st_valid", 64'(valid_D),     64'd1);
      end
      stall_F = 1'b0;
      step();
      chk("st_rel_pcD",   pc_D,             64'd16);
      chk("st_rel_count", 64'(fetch_count), 64'd5);
      chk("st_rel_addr",  64'(imem_addr),   64'd5);

      // Redirect wins over a simultaneous stall
      redirect_valid = 1'b1; redirect_pc = 64'h40; stall_F = 1'b1;
      step();
      redirect_valid = 1'b0; stall_F = 1'b0;
      chk("rd_valid", 64'(valid_D),     64'd0);
      chk("rd_addr",  64'(imem_addr),   64'd16);
      chk("rd_pcD",   pc_D,             64'd16);
      chk("rd_count", 64'(fetch_count), 64'd5);
      step();
      chk("rd2_pcD",   pc_D,             64'h40);
      chk("rd2_valid", 64'(valid_D),     64'd1);
      chk("rd2_instr", 64'(instr_D),     64'ha0000010);
      chk("rd2_count", 64'(fetch_count), 64'd6);

      // Halt at word 20, run from 0
      reset = 1'b1; step(); reset = 1'b0;
      chk_reset_state("rst2");
      for (int i = 0; i < 21; i++) step();
      chk("h_halted", 64'(halted),      64'd1);
      chk("h_instr",  64'(instr_D),     64'hb400001f);
      chk("h_valid",  64'(valid_D),     64'd1);
      chk("h_pcD",    pc_D,             64'd80);
      chk("h_addr",   64'(imem_addr),   64'd20);
      chk("h_count",  64'(fetch_count), 64'd21);
      stall_F = 1'b1;
      step();
      chk("h_stall_valid", 64'(valid_D), 64'd1);
      chk("h_stall_instr", 64'(instr_D), 64'hb400001f);
      stall_F = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'd80;
      step();
      chk("h_drain_valid", 64'(valid_D),     64'd0);
      chk("h_drain_addr",  64'(imem_addr),   64'd20);
      chk("h_drain_count", 64'(fetch_count), 64'd21);
      redirect_pc = 64'd0;
      step();
      chk("h_ignore_addr",  64'(imem_addr), 64'd20);
      chk("h_ignore_valid", 64'(valid_D),   64'd0);
      chk("h_ignore_fault", 64'(fault),     64'd0);
      redirect_valid = 1'b0;

      // Reset while halted
      reset = 1'b1; step(); reset = 1'b0;
      chk_reset_state("rst_halt");
      step();
      chk("rh_pcD",   pc_D,             64'd0);
      chk("rh_valid", 64'(valid_D),     64'd1);
      chk("rh_count", 64'(fetch_count), 64'd1);

      // Fault: redirect to ROM end
      redirect_valid = 1'b1; redirect_pc = 64'h400;
      step();
      redirect_valid = 1'b0;
      chk("f_end_valid0", 64'(valid_D),   64'd0);
      chk("f_end_fault0", 64'(fault),     64'd0);
      chk("f_end_addr0",  64'(imem_addr), 64'd0);
      step();
      chk("f_end_fault",  64'(fault),       64'd1);
      chk("f_end_valid",  64'(valid_D),     64'd0);
      chk("f_end_halted", 64'(halted),      64'd0);
      chk("f_end_count",  64'(fetch_count), 64'd1);
      redirect_valid = 1'b1; redirect_pc = 64'd8;
      step();
      redirect_valid = 1'b0;
      chk("f_frozen_addr",  64'(imem_addr), 64'd0);
      chk("f_frozen_fault", 64'(fault),     64'd1);

      // Fault: misaligned redirect target
      reset = 1'b1; step(); reset = 1'b0;
      step();
      redirect_valid = 1'b1; redirect_pc = 64'h42;
      step();
      redirect_valid = 1'b0;
      chk("f_mis_addr0", 64'(imem_addr), 64'd16);
      chk("f_mis_fault0", 64'(fault),    64'd0);
      step();
      chk("f_mis_fault", 64'(fault),   64'd1);
      chk("f_mis_valid", 64'(valid_D), 64'd0);
      step();
      chk("f_mis_addr", 64'(imem_addr), 64'd16);

      // Fetch of last ROM word, then wrap is caught as a fault
      reset = 1'b1; step(); reset = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 64'h3fc;
      step();
      redirect_valid = 1'b0;
      step();
      chk("w_pcD",   pc_D,           64'h3fc);
      chk("w_instr", 64'(instr_D),   64'ha00000ff);
      chk("w_valid", 64'(valid_D),   64'd1);
      chk("w_addr",  64'(imem_addr), 64'd0);
      chk("w_fault0", 64'(fault),    64'd0);
      step();
      chk("w_fault", 64'(fault),   64'd1);
      chk("w_valid2", 64'(valid_D), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined LEGv8 core.
- Owns the fetch PC and drives the word address of the 256x32 combinational instruction ROM.
- Captures the returned instruction into the IF/ID pipeline register and applies stall, branch-redirect flush and halt detection.
- Keeps a fetched-instruction counter for the testbench.

Parameters:
- N, 64, datapath/PC width.
- IW, 32, instruction width.
- AW, 8, ROM word-address width (256 words).
- HALT_INSN, 32'hb400001f, terminating self-loop encoding (CBZ XZR,#0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall_F  in  1  hazard unit: hold PC and IF/ID.
- redirect_valid  in  1  taken branch resolved downstream.
- redirect_pc  in  N  byte address of branch target.
- imem_addr  out  AW  ROM word address.
- imem_q  in  IW  ROM data (combinational, same cycle).
- instr_D  out  IW  IF/ID instruction.
- pc_D  out  N  IF/ID PC of instr_D.
- valid_D  out  1  IF/ID holds a real instruction.
- halted  out  1  halt instruction fetched; fetch frozen.
- fault  out  1  PC outside ROM or misaligned; fetch frozen.
- fetch_count  out  32  instructions accepted into IF/ID, saturating.

Behaviour:
- Reset (synchronous, highest priority):
  - pc_F=0, state=RUN.
  - instr_D=0, pc_D=0, valid_D=0.
  - halted=0, fault=0, fetch_count=0.
  - Reset mid-halt or mid-stall returns to RUN with pc_F=0.
- imem_addr = pc_F[AW+1:2], combinational from the PC register. Fetch latency: instruction at pc_F appears in IF/ID one edge later.
- States: RUN, HALT, FAULT. Per-edge priority in RUN: reset > redirect > fault check > stall > normal.
- Redirect: redirect_valid=1 in RUN, regardless of stall_F:
  - pc_F<=redirect_pc; valid_D<=0 (flush); instr_D, pc_D, fetch_count unchanged.
  - Redirect wins over a simultaneous stall.
- Fault check: when no redirect and pc_F[N-1:AW+2]!=0 or pc_F[1:0]!=0:
  - state<=FAULT, fault<=1, valid_D<=0.
- Stall: stall_F=1 and no redirect or fault. pc_F, instr_D, pc_D, valid_D and fetch_count all hold.
- Normal:
  - instr_D<=imem_q, pc_D<=pc_F, valid_D<=1, fetch_count+=1 (saturate at 32'hffffffff).
  - If imem_q==HALT_INSN: state<=HALT, halted<=1, pc_F holds. Otherwise pc_F<=pc_F+4.
  - Wrap of pc_F+4 past ROM end (word 255 -> byte 1024) is caught by the fault check on the next cycle.
- HALT:
  - The halt instruction, already in IF/ID, drains normally under stall_F. While stall_F=1 the register holds it.
  - On the first non-stalled edge valid_D<=0. Thereafter valid_D stays 0 and pc_F is frozen.
  - redirect_valid is ignored (the self-loop CBZ resolves to its own PC). fetch_count frozen. Exit only by reset.
- FAULT: same freeze as HALT, with valid_D=0 immediately. Exit only by reset.
- halted and fault are sticky and mutually exclusive.
- No combinational path from redirect_valid or stall_F to imem_addr.

Decomposition:
- Shared package fetch_pkg:
  - state enum fetch_state_t {RUN, HALT, FAULT}.
  - HALT_INSN constant.
  - ROM-depth constant.
  - Width constants reused by imem and the IF/ID path.
- One natural sub-module: if_id_reg. Holds instr_D, pc_D, valid_D, with en (hold) and flush inputs and synchronous reset.
- PC logic, FSM and counter stay in fetch_ctrl.

Test Plan:
1. Straight-line: reset 2 cycles, then 4 idle cycles.
   - imem_addr=0,1,2,3.
   - pc_D=0,4,8,12; instr_D=ROM words 0..3.
   - valid_D=1 from first edge after reset; fetch_count=4.
2. Stall: assert stall_F for 3 cycles at pc_F=16.
   - imem_addr holds 4; instr_D/pc_D hold previous word (pc_D=12); fetch_count unchanged.
   - On release, pc_D=16 next edge.
3. Redirect with stall: redirect_valid=1, redirect_pc=0x40, stall_F=1 same cycle.
   - Next cycle valid_D=0 and imem_addr=16.
   - Following edge pc_D=0x40, valid_D=1.
4. Halt: ROM word 20 = 32'hb400001f, run from 0.
   - After fetching pc=80: halted=1, imem_addr stays 20, instr_D=32'hb400001f with valid_D=1 for one cycle, then valid_D=0.
   - redirect_pc=80 ignored; fetch_count=21.
5. Fault: redirect_pc=0x400 (ROM end) -> next edge fault=1, valid_D=0, pc_F frozen. Repeat with redirect_pc=0x42 (misaligned) -> fault=1.
6. Reset mid-halt: assert reset while halted=1.
   - All outputs return to reset values, state=RUN.
   - Next edge pc_D=0, valid_D=1.
